// File: rtl/booth_multiplier_seq.sv
// Sequential signed N x N -> 2N multiplier using radix-2 Booth recoding.
// Latency: start accepted at edge 0, N iterate edges, done/product registered one edge later (N+1).
// No backpressure: start is only sampled in IDLE and ignored while busy; product holds until the next result.
module booth_multiplier_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(N);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N:0]    a;        // partial product, one guard bit so M = -2^(N-1) cannot overflow
  logic [N-1:0]  q;        // multiplier, shifted out LSB-first
  logic          q_m1;     // previously shifted-out multiplier bit
  logic [N:0]    m;        // sign-extended multiplicand
  logic [CW-1:0] count;    // iterations remaining

  logic          op_sub;
  logic          op_en;
  logic [N:0]    addend;
  logic [N:0]    a_sum;
  logic [N:0]    a_new;

  // Booth pair decode feeding the add/subtract primitive: 01 -> A+M, 10 -> A+~M+1, else hold
  always_comb begin
    op_sub = q[0] & ~q_m1;
    op_en  = q[0] ^ q_m1;
    addend = op_sub ? ~m : m;
    a_sum  = a + addend + {{N{1'b0}}, op_sub};
    a_new  = op_en ? a_sum : a;
  end

  // Control FSM and datapath registers; all outputs are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m       <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {multiplicand[N-1], multiplicand};
            q     <= multiplier;
            a     <= '0;
            q_m1  <= 1'b0;
            count <= COUNT_INIT;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // arithmetic shift of {A_new, Q, q_m1}: A's sign bit is replicated
          {a, q, q_m1} <= {a_new[N], a_new, q};
          count        <= count - COUNT_ONE;
          if (count == COUNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          // product and done are written on the same edge so they appear together
          product <= {a[N-1:0], q};
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq (N=8): reset, signs, corners,
// ignored start, async abort and a held-start sweep against a signed model.
module tb_booth_multiplier_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks;
  int n_fail;

  booth_multiplier_seq #(.N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from IDLE and wait (bounded) for done.
  // lat counts edges after the accepting edge; -1 means done never came.
  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp,
                        output logic [15:0] prod, output int lat, output logic busy0);
    @(negedge clk);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    prod = product;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int          lat;
    logic        b0;
    run_op(8'd3, 8'd5, p, lat, b0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", b0); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_checks++;
    if (p !== 16'h000F) begin n_fail++; $display("FAIL basic_product got %h want 000f", p); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_single got %b want 0", done); end
    n_checks++;
    if (product !== 16'h000F) begin n_fail++; $display("FAIL basic_product_hold got %h want 000f", product); end
  endtask

  task automatic test_signs();
    logic [15:0] p;
    int          lat;
    logic        b0;
    run_op(8'hF9, 8'd6, p, lat, b0);
    n_checks++;
    if (p !== 16'hFFD6) begin n_fail++; $display("FAIL sign_neg_pos got %h want ffd6", p); end
    run_op(8'd6, 8'hF9, p, lat, b0);
    n_checks++;
    if (p !== 16'hFFD6) begin n_fail++; $display("FAIL sign_pos_neg got %h want ffd6", p); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL sign_latency got %0d want 9", lat); end
  endtask

  task automatic test_corners();
    logic [15:0] p;
    int          lat;
    logic        b0;
    run_op(8'h80, 8'h80, p, lat, b0);
    n_checks++;
    if (p !== 16'h4000) begin n_fail++; $display("FAIL corner_min_min got %h want 4000", p); end
    run_op(8'h80, 8'h7F, p, lat, b0);
    n_checks++;
    if (p !== 16'hC080) begin n_fail++; $display("FAIL corner_min_max got %h want c080", p); end
    run_op(8'h7F, 8'h7F, p, lat, b0);
    n_checks++;
    if (p !== 16'h3F01) begin n_fail++; $display("FAIL corner_max_max got %h want 3f01", p); end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int first_done;
    int busy_edges;
    @(negedge clk);
    multiplicand = 8'd0;
    multiplier   = 8'hA5;
    start        = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    n_done     = 0;
    first_done = -1;
    busy_edges = busy ? 1 : 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_edges++;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
    n_checks++;
    if (first_done !== 9) begin n_fail++; $display("FAIL ignore_latency got %0d want 9", first_done); end
    n_checks++;
    if (busy_edges !== 9) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 9", busy_edges); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL ignore_product got %h want 0000", product); end
  endtask

  task automatic test_async_reset();
    logic [15:0] p;
    int          lat;
    logic        b0;
    int          n_done;
    // leave a nonzero product behind so the clear is observable
    run_op(8'd3, 8'd5, p, lat, b0);
    @(negedge clk);
    multiplicand = 8'd3;
    multiplier   = 8'd5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", done); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL areset_product got %h want 0000", product); end
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL areset_no_done got %0d want 0", n_done); end
    run_op(8'd2, 8'hFE, p, lat, b0);
    n_checks++;
    if (p !== 16'hFFFC) begin n_fail++; $display("FAIL areset_after_product got %h want fffc", p); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL areset_after_latency got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0]  mc;
    logic signed [7:0]  mp;
    logic signed [15:0] expv;
    int                 gap;
    @(negedge clk);
    mc = 8'($urandom);
    mp = 8'($urandom);
    expv = mc * mp;
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      gap = -1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (done) begin
          gap = c;
          break;
        end
      end
      n_checks++;
      if (gap !== 10) begin
        n_fail++;
        $display("FAIL b2b_spacing op %0d got %0d want 10", i, gap);
      end
      n_checks++;
      if (product !== expv) begin
        n_fail++;
        $display("FAIL b2b_product op %0d (%0d*%0d) got %h want %h", i, mc, mp, product, expv);
      end
      // the next accepting edge is the one right after this done cycle
      mc = 8'($urandom);
      mp = 8'($urandom);
      expv = mc * mp;
      multiplicand = mc;
      multiplier   = mp;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_signs();
    test_corners();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Sequential signed (two's-complement) N x N -> 2N multiplier using radix-2 Booth recoding.
- One add, subtract or no-op per clock on an (N+1)-bit partial-product register, followed by an arithmetic right shift.
- Sits downstream of the team's add/subtract datapath: it consumes the add/subtract primitive once per iteration and drives it with an add/subtract control bit derived from Booth pairs.
- Start/busy/done handshake; result held until the next operation.

Parameters:
- N, 8, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  N  signed operand M; captured when start is accepted.
- multiplier  input  N  signed operand Q; captured when start is accepted.
- busy  output  1  high while in CALC or DONE.
- done  output  1  single-cycle pulse in DONE; product is valid from this cycle onward.
- product  output  2N  signed result M*Q; held until the next result is written.

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE. Internal registers A, Q, q_m1, M and count are all 0.
- Reset asserted mid-operation aborts the operation. The FSM returns to IDLE, product is cleared to 0, and no done pulse is produced.
- IDLE state:
  - busy=0.
  - On start=1 at a clock edge: M <= sign-extend(multiplicand) to N+1 bits; Q <= multiplier; A <= 0; q_m1 <= 0; count <= N; next state CALC.
- CALC state (exactly N cycles):
  - Each cycle, select an operation from {Q[0], q_m1}:
    - 00 or 11: A unchanged.
    - 01: A + M.
    - 10: A - M, computed as A + ~M + 1.
  - Then arithmetic-shift {A_new, Q, q_m1} right by 1; A's MSB is replicated.
  - count decrements each cycle. When count reaches 1, the current iteration is the last one; next state is DONE.
  - A is N+1 bits, so M = -2^(N-1) never overflows. No overflow flag exists and none is needed.
- DONE state (1 cycle):
  - product <= {A[N-1:0], Q}, the lower 2N bits of the final {A,Q}.
  - Registered so that product and done become visible together: done=1 and product valid in the same cycle.
  - Next state IDLE.
- Latency: start accepted at edge 0 -> N CALC edges -> done high during the cycle after edge N+1. Worst-case throughput is one result per N+2 cycles.
- start is ignored while busy=1 (CALC or DONE). Operand inputs are don't-care except at the accepting edge.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE. Back-to-back spacing is N+2 cycles.
- product is stable between done pulses, including while a new operation runs.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- N=8, reset released, start with multiplicand=3, multiplier=5 -> busy rises next cycle; done pulses exactly once, 9 cycles after the accepting edge; product=16'h000F.
- multiplicand=-7 (8'hF9), multiplier=6 -> product=16'hFFD6 (-42). Then multiplicand=6, multiplier=-7 -> same product.
- Corner operands:
  - multiplicand=-128, multiplier=-128 -> product=16'h4000.
  - multiplicand=-128, multiplier=127 -> product=16'hC080.
  - multiplicand=127, multiplier=127 -> product=16'h3F01.
- multiplicand=0, multiplier=8'hA5 -> product=0. Then pulse start again during CALC with different operands -> the pulse is ignored, exactly one done is seen, product=0, and busy timing is unchanged.
- Start 3*5. Assert reset asynchronously (between edges) at CALC cycle 4 -> busy=0, done=0, product=0 immediately. Release reset, start 2*-2 -> product=16'hFFFC with normal latency.
- Randomized sweep of 1000 operand pairs against a signed reference model, with start held high -> every result matches, and done pulses are spaced exactly 10 cycles apart.
